// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single memory request bus
//
// Purpose: arbitrates an instruction-fetch port and a data port onto one memory
// bus, with a per-transaction 8-bit timeout that completes the access with bus_err.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (level) and address
//   if_rdata/if_ready             fetched word and one-cycle completion pulse
//   dm_read/dm_write/dm_size      data request (level), size 00/11=word 01=half 10=byte
//   dm_addr/dm_wdata              data address and store data
//   dm_rdata/dm_ready             raw load word and one-cycle completion pulse
//   mem_req/mem_we/mem_size       memory request (held until mem_ack), write enable, size
//   mem_addr/mem_wdata            memory address and write data
//   mem_rdata/mem_ack             memory read data and completion strobe
//   stall_if/stall_dm             per-port pending indications
//   bus_err                       timeout pulse, coincident with the ready pulse
//
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration when both ports
// request together; otherwise the data port has fixed priority.

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_dm,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] cmd_addr_q;
    logic [31:0] cmd_wdata_q;
    logic [1:0]  cmd_size_q;
    logic        cmd_we_q;
    logic        mem_req_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;
    logic        if_ready_q;
    logic        dm_ready_q;
    logic        bus_err_q;
    logic [7:0]  tmo_cnt_q;

    logic        dm_req;
    logic        grant_dm_d;

    assign dm_req = dm_read | dm_write;

`ifdef MEM_ARB_RR_EN
    // 1 when the data port won the most recent grant; reset value means fetch.
    logic last_grant_dm_q;

    always_comb begin
        grant_dm_d = dm_req;
        if (dm_req && if_req) begin
            grant_dm_d = ~last_grant_dm_q;
        end
    end
`else
    // Data port wins whenever it requests.
    assign grant_dm_d = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_addr_q  <= 32'h0;
            cmd_wdata_q <= 32'h0;
            cmd_size_q  <= 2'b00;
            cmd_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            tmo_cnt_q   <= 8'h0;
`ifdef MEM_ARB_RR_EN
            last_grant_dm_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (dm_req || if_req) begin
                        mem_req_q <= 1'b1;
                        tmo_cnt_q <= 8'h0;
`ifdef MEM_ARB_RR_EN
                        last_grant_dm_q <= grant_dm_d;
`endif
                        if (grant_dm_d) begin
                            // A simultaneous read and write resolves to a write.
                            cmd_addr_q  <= dm_addr;
                            cmd_wdata_q <= dm_wdata;
                            cmd_size_q  <= dm_size;
                            cmd_we_q    <= dm_write;
                            state_q     <= DM_BUSY;
                        end else begin
                            cmd_addr_q  <= if_addr;
                            cmd_wdata_q <= 32'h0;
                            cmd_size_q  <= 2'b00;
                            cmd_we_q    <= 1'b0;
                            state_q     <= IF_BUSY;
                        end
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (mem_ack) begin
                        tmo_cnt_q <= 8'h0;
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (state_q == IF_BUSY) begin
                            if_rdata_q <= mem_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            dm_rdata_q <= mem_rdata;
                            dm_ready_q <= 1'b1;
                        end
                    end else if (tmo_cnt_q == 8'd254) begin
                        // This busy cycle brings the count to 255: give up.
                        tmo_cnt_q <= 8'd255;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                        if (state_q == IF_BUSY) begin
                            if_rdata_q <= 32'h0;
                            if_ready_q <= 1'b1;
                        end else begin
                            dm_rdata_q <= 32'h0;
                            dm_ready_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    // Single-cycle completion; no arbitration here, so a request
                    // still held at this edge is not re-granted until IDLE.
                    if_ready_q <= 1'b0;
                    dm_ready_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_we_q;
    assign mem_size  = cmd_size_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign bus_err   = bus_err_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_dm  = dm_req & ~dm_ready_q;

endmodule
